// File: rtl/chnl_rx.sv
// chnl_rx -- buffered Riffa CHNL receiver.
//
// Accepts host->FPGA transfers on the CHNL_RX interface, stores the PCIe beats
// in a 1024-entry fifo and repacks them into an RX_WIDTH valid/ready stream.
// Everything runs on clk; CHNL_RX_CLK simply forwards it to the endpoint.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   o_val/o_rdy/o_data  output word stream (RX_WIDTH bits)
//   o_err               only with CHNL_RX_ERR_EN: sticky protocol-error flag
//   CHNL_RX_CLK         clock handed back to the Riffa endpoint
//   CHNL_RX/_ACK        transfer request / one-cycle acknowledge
//   CHNL_RX_LAST        ignored (host always sends single-part transfers)
//   CHNL_RX_LEN         transfer length in 32-bit words
//   CHNL_RX_OFF         ignored for the datapath (host always sends 0)
//   CHNL_RX_DATA*       beat data; beat taken when DATA_VALID && DATA_REN
//
// Build option
//   CHNL_RX_ERR_EN  adds o_err: set on a misaligned LEN, a non-zero OFF or a
//                   host abort; cleared only by rst. Datapath is unchanged.
module chnl_rx #(
    parameter int C_PCI_DATA_WIDTH = 32,
    parameter int RX_WIDTH         = 32,
    parameter int GCD              = 32,
    parameter int CHNL_ALIGN       = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        o_val,
    input  logic                        o_rdy,
    output logic [RX_WIDTH-1:0]         o_data,
`ifdef CHNL_RX_ERR_EN
    output logic                        o_err,
`endif
    output logic                        CHNL_RX_CLK,
    input  logic                        CHNL_RX,
    output logic                        CHNL_RX_ACK,
    input  logic                        CHNL_RX_LAST,
    input  logic [31:0]                 CHNL_RX_LEN,
    input  logic [30:0]                 CHNL_RX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    input  logic                        CHNL_RX_DATA_VALID,
    output logic                        CHNL_RX_DATA_REN
);

    localparam int WPB   = C_PCI_DATA_WIDTH / 32;   // 32-bit words per beat
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int IN_L  = C_PCI_DATA_WIDTH / GCD;  // lanes per beat
    localparam int OUT_L = RX_WIDTH / GCD;          // lanes per output word
    localparam int BUF_L = IN_L + OUT_L;            // repacker capacity in lanes
    localparam int CW    = $clog2(BUF_L + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RECV = 1'b1;

    logic unused_ok;
    assign unused_ok   = ^{CHNL_RX_LAST, CHNL_RX_OFF};
    assign CHNL_RX_CLK = clk;

    // ------------------------------------------------------------------
    // Transfer control
    // ------------------------------------------------------------------
    logic [0:0]  state;
    logic [31:0] cnt_left;
    logic        hold;       // request already acknowledged; wait for it to fall
    logic [31:0] beats;
    logic [32:0] len_rnd;
    logic        fifo_in_rdy;
    logic        acc, last_acc, abort;

    // Round up to whole beats; 33 bits so a huge LEN cannot wrap.
    assign len_rnd = {1'b0, CHNL_RX_LEN} + 33'(WPB - 1);
    assign beats   = 32'(len_rnd / 33'(WPB));

    assign CHNL_RX_ACK      = (state == S_IDLE) && CHNL_RX && !hold;
    assign CHNL_RX_DATA_REN = (state == S_RECV) && fifo_in_rdy;
    assign acc              = CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN;
    assign last_acc         = acc && (cnt_left == 32'd1);
    assign abort            = (state == S_RECV) && !CHNL_RX && !last_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt_left <= '0;
            hold     <= 1'b0;
        end else begin
            if (!CHNL_RX)         hold <= 1'b0;
            else if (CHNL_RX_ACK) hold <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (CHNL_RX_ACK) begin
                        cnt_left <= beats;
                        // A zero-length request is acknowledged but carries no data.
                        if (beats != 32'd0) state <= S_RECV;
                    end
                end
                default: begin
                    if (acc) cnt_left <= cnt_left - 32'd1;
                    if (last_acc) begin
                        state <= S_IDLE;
                    end else if (abort) begin
                        // Host gave up: drop the remaining count, keep what arrived.
                        state    <= S_IDLE;
                        cnt_left <= '0;
                    end
                end
            endcase
        end
    end

`ifdef CHNL_RX_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_err <= 1'b0;
        end else if (CHNL_RX_ACK &&
                     ((CHNL_RX_LEN % 32'(CHNL_ALIGN)) != 32'd0 || CHNL_RX_OFF != 31'd0)) begin
            o_err <= 1'b1;
        end else if (abort) begin
            o_err <= 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Beat fifo: RAM plus one output register (registered read)
    // ------------------------------------------------------------------
    logic [C_PCI_DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]               wptr, rptr;
    logic [AW:0]                 mcnt;
    logic                        fv;
    logic [C_PCI_DATA_WIDTH-1:0] fdata;
    logic                        f_take, ld;

    assign fifo_in_rdy = (mcnt != (AW+1)'(DEPTH));
    assign ld          = (mcnt != '0) && (!fv || f_take);

    always_ff @(posedge clk) begin
        if (acc) mem[wptr] <= CHNL_RX_DATA;
        if (ld)  fdata     <= mem[rptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            mcnt <= '0;
            fv   <= 1'b0;
        end else begin
            if (acc) wptr <= wptr + AW'(1);
            if (ld)  rptr <= rptr + AW'(1);
            case ({acc, ld})
                2'b10:   mcnt <= mcnt + (AW+1)'(1);
                2'b01:   mcnt <= mcnt - (AW+1)'(1);
                default: ;
            endcase
            if (ld)          fv <= 1'b1;
            else if (f_take) fv <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Repacker: lane buffer, lane 0 is the next lane to leave
    // ------------------------------------------------------------------
    logic [BUF_L-1:0][GCD-1:0] pbuf, pnxt;
    logic [IN_L-1:0][GCD-1:0]  f_lanes;
    logic [CW-1:0]             pcnt, pcnt_nxt;
    logic                      pop;
    int                        rp_base;

    assign f_lanes = fdata;
    // Admission ignores this cycle's pop, which keeps o_rdy off the fifo path.
    assign f_take  = fv && (int'(pcnt) + IN_L <= BUF_L);
    assign o_val   = (int'(pcnt) >= OUT_L);
    assign pop     = o_val && o_rdy;
    assign o_data  = pbuf[OUT_L-1:0];

    always_comb begin
        pnxt    = pbuf;
        rp_base = int'(pcnt);
        if (pop) begin
            for (int i = 0; i < BUF_L - OUT_L; i++) pnxt[i] = pbuf[i+OUT_L];
            for (int i = BUF_L - OUT_L; i < BUF_L; i++) pnxt[i] = '0;
            rp_base = rp_base - OUT_L;
        end
        if (f_take) begin
            for (int i = 0; i < BUF_L; i++)
                for (int j = 0; j < IN_L; j++)
                    if (i == rp_base + j) pnxt[i] = f_lanes[j];
        end
        pcnt_nxt = CW'(rp_base + (f_take ? IN_L : 0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pbuf <= '0;
            pcnt <= '0;
        end else begin
            pbuf <= pnxt;
            pcnt <= pcnt_nxt;
        end
    end

endmodule

// File: tb/tb_chnl_rx.sv
module tb_chnl_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // DUT A: 64-bit beats, 32-bit output words
    logic        o_val, o_rdy;
    logic [31:0] o_data;
    logic        rx_clk, rx, ack, last, dvalid, ren;
    logic [31:0] len;
    logic [30:0] off;
    logic [63:0] data;
`ifdef CHNL_RX_ERR_EN
    logic        o_err;
`endif

    // DUT B: 32-bit beats, 32-bit output words
    logic        o_val_b, o_rdy_b;
    logic [31:0] o_data_b;
    logic        rx_clk_b, rx_b, ack_b, last_b, dvalid_b, ren_b;
    logic [31:0] len_b;
    logic [30:0] off_b;
    logic [31:0] data_b;
`ifdef CHNL_RX_ERR_EN
    logic        o_err_b;
`endif

    chnl_rx #(.C_PCI_DATA_WIDTH(64), .RX_WIDTH(32), .GCD(32), .CHNL_ALIGN(4)) dut (
        .clk(clk), .rst(rst), .o_val(o_val), .o_rdy(o_rdy), .o_data(o_data),
`ifdef CHNL_RX_ERR_EN
        .o_err(o_err),
`endif
        .CHNL_RX_CLK(rx_clk), .CHNL_RX(rx), .CHNL_RX_ACK(ack), .CHNL_RX_LAST(last),
        .CHNL_RX_LEN(len), .CHNL_RX_OFF(off), .CHNL_RX_DATA(data),
        .CHNL_RX_DATA_VALID(dvalid), .CHNL_RX_DATA_REN(ren)
    );

    chnl_rx #(.C_PCI_DATA_WIDTH(32), .RX_WIDTH(32), .GCD(32), .CHNL_ALIGN(4)) dut_b (
        .clk(clk), .rst(rst), .o_val(o_val_b), .o_rdy(o_rdy_b), .o_data(o_data_b),
`ifdef CHNL_RX_ERR_EN
        .o_err(o_err_b),
`endif
        .CHNL_RX_CLK(rx_clk_b), .CHNL_RX(rx_b), .CHNL_RX_ACK(ack_b), .CHNL_RX_LAST(last_b),
        .CHNL_RX_LEN(len_b), .CHNL_RX_OFF(off_b), .CHNL_RX_DATA(data_b),
        .CHNL_RX_DATA_VALID(dvalid_b), .CHNL_RX_DATA_REN(ren_b)
    );

    int checks = 0;
    int errors = 0;
    int q[$];
    int qb[$];
    int ack_cnt = 0, ren_cnt = 0, oval_cnt = 0, ack_cnt_b = 0;
    int beats_sent = 0;
    logic        stall_p = 1'b0;
    logic [31:0] stall_d = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor / scoreboard for DUT A
    always @(negedge clk) begin
        if (rst) begin
            stall_p = 1'b0;
        end else begin
            if (ack)   ack_cnt++;
            if (ren)   ren_cnt++;
            if (o_val) oval_cnt++;
            if (stall_p) begin
                chk("stall_val", o_val, 1);
                chk("stall_data", o_data, stall_d);
            end
            if (o_val && o_rdy) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0d expected none", o_data);
                end else begin
                    chk("word", o_data, q.pop_front());
                end
            end
            stall_p = o_val && !o_rdy;
            stall_d = o_data;
        end
    end

    // Monitor / scoreboard for DUT B
    always @(negedge clk) begin
        if (!rst) begin
            if (ack_b) ack_cnt_b++;
            if (o_val_b && o_rdy_b) begin
                if (qb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word_b: got %0d expected none", o_data_b);
                end else begin
                    chk("word_b", o_data_b, qb.pop_front());
                end
            end
        end
    end

    // Host transfer on DUT A: beat k carries words base+2k+1 (low) and base+2k+2 (high).
    task automatic xfer(input int l, input int nsend, input int base, input bit keep_rx);
        int  t;
        bit  got;
        bit  a;
        @(posedge clk); #1;
        rx  = 1'b1;
        len = l;
        got = 1'b0;
        t   = 0;
        while (!got && t < 20) begin
            @(negedge clk);
            got = ack;
            t++;
        end
        chk("ack_seen", got, 1);
        @(posedge clk); #1;
        beats_sent = 0;
        t = 0;
        while (beats_sent < nsend && t < 20000) begin
            data   = {32'(base + 2*beats_sent + 2), 32'(base + 2*beats_sent + 1)};
            dvalid = 1'b1;
            @(negedge clk);
            a = ren;
            @(posedge clk); #1;
            if (a) begin
                q.push_back(base + 2*beats_sent + 1);
                q.push_back(base + 2*beats_sent + 2);
                beats_sent++;
            end
            t++;
        end
        chk("beats_sent", beats_sent, nsend);
        dvalid = 1'b0;
        if (!keep_rx) rx = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while ((q.size() != 0 || qb.size() != 0) && t < 10000) begin
            @(posedge clk);
            t++;
        end
        chk(name, q.size() + qb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, r0, v0, t;
        bit got, a;
        rst = 1'b1;
        rx = 0; last = 0; len = 0; off = 0; data = 0; dvalid = 0; o_rdy = 1;
        rx_b = 0; last_b = 0; len_b = 0; off_b = 0; data_b = 0; dvalid_b = 0; o_rdy_b = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ren", ren, 0);
        chk("rst_oval", o_val, 0);
        chk("rst_ren_b", ren_b, 0);
        chk("rst_oval_b", o_val_b, 0);
`ifdef CHNL_RX_ERR_EN
        chk("rst_err", o_err, 0);
`endif
        rst = 1'b0;

        // 32/32, LEN=4, words 1..4; request held after completion must not re-trigger
        @(posedge clk); #1;
        rx_b = 1; len_b = 4;
        got = 0; t = 0;
        while (!got && t < 20) begin @(negedge clk); got = ack_b; t++; end
        chk("b_ack_seen", got, 1);
        @(posedge clk); #1;
        t = 0;
        for (int i = 0; i < 4 && t < 100; ) begin
            data_b = 32'(i + 1); dvalid_b = 1;
            @(negedge clk); a = ren_b;
            @(posedge clk); #1;
            if (a) begin qb.push_back(i + 1); i++; end
            t++;
        end
        dvalid_b = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("b_ren_idle", ren_b, 0);
        rx_b = 0;
        drain("b_drain");
        chk("b_ack_count", ack_cnt_b, 1);

        // 64->32 repack: words 1..8 in order
        a0 = ack_cnt;
        xfer(8, 4, 0, 0);
        drain("repack_drain");
        chk("repack_acks", ack_cnt - a0, 1);

        // LEN=0: ACK once even with request held, no REN, no output
        a0 = ack_cnt; r0 = ren_cnt; v0 = oval_cnt;
        xfer(0, 0, 0, 1);
        repeat (5) @(posedge clk);
        #1; rx = 0;
        repeat (3) @(posedge clk);
        chk("len0_acks", ack_cnt - a0, 1);
        chk("len0_ren", ren_cnt - r0, 0);
        chk("len0_oval", oval_cnt - v0, 0);
        xfer(4, 2, 100, 0);
        drain("after_len0_drain");
        chk("after_len0_acks", ack_cnt - a0, 2);

        // Host abort after 3 of 4 beats: 6 words still delivered
        xfer(8, 3, 200, 1);
        @(posedge clk); #1; rx = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_ren", ren, 0);
        drain("abort_drain");
`ifdef CHNL_RX_ERR_EN
        chk("abort_err", o_err, 1);
`endif
        xfer(4, 2, 300, 0);
        drain("after_abort_drain");

        // Fill with o_rdy low: 1024 fifo + 1 output reg + 1 repacker beat, then drain all
        @(posedge clk); #1; o_rdy = 0;
        fork
            xfer(4400, 2200, 1000, 0);
            begin
                repeat (1300) @(posedge clk);
                @(negedge clk);
                chk("fill_level", beats_sent, 1026);
                chk("fill_ren", ren, 0);
                @(posedge clk); #1;
                o_rdy = 1;
            end
        join
        drain("fill_drain");

        // Reset after 2 of 4 beats: outputs clear, no stale data afterwards
        xfer(8, 2, 6000, 1);
        @(posedge clk); #1;
        rst = 1; rx = 0;
        @(posedge clk); #1;
        rst = 0;
        chk("mid_rst_ren", ren, 0);
        chk("mid_rst_oval", o_val, 0);
        q.delete();
        v0 = oval_cnt;
        repeat (5) @(posedge clk);
        chk("mid_rst_empty", oval_cnt - v0, 0);
`ifdef CHNL_RX_ERR_EN
        chk("mid_rst_err", o_err, 0);
`endif
        xfer(4, 2, 7000, 0);
        drain("post_rst_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
